microwave_cook_ctrl: RTL and testbench

Cook-cycle controller for the microwave timer datapath. It sequences the timer-source multiplexer, which chooses between the keypad-entry pulse path and the 1 Hz countdown path. It gates the magnetron, clears and loads the timer, enforces door interlock, and times the end-of-cook beep. It sits between the keypad/door/button inputs and the timer-source mux plus countdown chain.

---
 rtl/microwave_pkg.sv | 17 +
 rtl/mw_beep_timer.sv | 40 ++++
 rtl/microwave_cook_ctrl.sv | 123 ++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared state encodings and default sizing for the microwave cook-cycle controller.
package microwave_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_MAX_DIGITS  = 4;
    localparam int DEF_BEEP_TICKS  = 3;
    localparam int BEEP_W          = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mw_beep_timer.sv
// Done-beep duration counter: loads TICKS on DONE entry, counts tick_i down to zero.
// done_o flags the tick that consumes the last count, so the FSM can leave DONE on that edge.
module mw_beep_timer
    import microwave_pkg::*;
#(
    parameter int TICKS = DEF_BEEP_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic tick_i,
    output logic done_o
);

    localparam logic [BEEP_W-1:0] LOAD_VAL = BEEP_W'(TICKS);
    localparam logic [BEEP_W-1:0] ONE      = BEEP_W'(1);

    logic [BEEP_W-1:0] cnt_q;
    logic [BEEP_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = tick_i && !load_i && (cnt_q == ONE);

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle FSM: steers the timer-source mux, gates the magnetron, shifts/clears the timer, beeps on done.
// All outputs are registered from next-state decode, so they change on the edge that changes the state.
module microwave_cook_ctrl
    import microwave_pkg::*;
#(
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int BEEP_TICKS = DEF_BEEP_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic               start,
    input  logic               stop_clear,
    input  logic               door_closed,
    input  logic               timer_zero,
    input  logic               tick_1hz,
    output logic               mux_sel,
    output logic               mag_on,
    output logic               shift_en,
    output logic               clear_timer,
    output logic               beep,
    output logic [STATE_W-1:0] state_o
);

    localparam int              CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dig_cnt_q, dig_cnt_d;
    logic             shift_en_q, shift_en_d;
    logic             clear_q, clear_d;
    logic             mag_on_q, mag_on_d;
    logic             mux_sel_q, mux_sel_d;
    logic             beep_q, beep_d;
    logic             beep_load;
    logic             beep_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!stop_clear && key_valid) state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (stop_clear)                                   state_d = ST_IDLE;
                else if (start && door_closed && !timer_zero)     state_d = ST_COOK;
            end
            ST_COOK: begin
                // Door interlock outranks the button, which outranks end-of-time.
                if (!door_closed || stop_clear) state_d = ST_PAUSE;
                else if (timer_zero)            state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (stop_clear)                  state_d = ST_IDLE;
                else if (start && door_closed)   state_d = ST_COOK;
            end
            ST_DONE: begin
                if (stop_clear || beep_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en_d = key_valid && (state_d == ST_ENTRY) &&
                     ((state_q == ST_IDLE) || ((state_q == ST_ENTRY) && (dig_cnt_q < MAX_CNT)));
        clear_d    = stop_clear && (state_d == ST_IDLE) &&
                     ((state_q == ST_IDLE) || (state_q == ST_ENTRY) || (state_q == ST_PAUSE));
        // Count only lives while in ENTRY; any exit drops it back to zero.
        if (shift_en_d)                dig_cnt_d = dig_cnt_q + CNT_ONE;
        else if (state_d == ST_ENTRY)  dig_cnt_d = dig_cnt_q;
        else                           dig_cnt_d = '0;
        mag_on_d   = (state_d == ST_COOK);
        mux_sel_d  = (state_d == ST_COOK);
        beep_d     = (state_d == ST_DONE);
        beep_load  = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_cnt_q  <= '0;
            shift_en_q <= 1'b0;
            clear_q    <= 1'b0;
            mag_on_q   <= 1'b0;
            mux_sel_q  <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            dig_cnt_q  <= dig_cnt_d;
            shift_en_q <= shift_en_d;
            clear_q    <= clear_d;
            mag_on_q   <= mag_on_d;
            mux_sel_q  <= mux_sel_d;
            beep_q     <= beep_d;
        end
    end

    mw_beep_timer #(
        .TICKS (BEEP_TICKS)
    ) u_beep_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (beep_load),
        .tick_i (tick_1hz && (state_q == ST_DONE)),
        .done_o (beep_done)
    );

    assign mux_sel     = mux_sel_q;
    assign mag_on      = mag_on_q;
    assign shift_en    = shift_en_q;
    assign clear_timer = clear_q;
    assign beep        = beep_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed-vector bench for microwave_cook_ctrl with hand-computed expectations.
module tb_microwave_cook_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, start, stop_clear, door_closed, timer_zero, tick_1hz;
    logic       mux_sel, mag_on, shift_en, clear_timer, beep;
    logic [2:0] state_o;

    int n_vec  = 0;
    int n_miss = 0;
    int shift_cnt = 0;
    int clear_cnt = 0;
    int base;

    always #5 clk = ~clk;

    microwave_cook_ctrl #(
        .MAX_DIGITS (4),
        .BEEP_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .tick_1hz    (tick_1hz),
        .mux_sel     (mux_sel),
        .mag_on      (mag_on),
        .shift_en    (shift_en),
        .clear_timer (clear_timer),
        .beep        (beep),
        .state_o     (state_o)
    );

    // Pulse tallies sampled mid-cycle, away from the edge that updates them.
    always @(negedge clk) begin
        if (shift_en)    shift_cnt++;
        if (clear_timer) clear_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_key();   key_valid  = 1'b1; step(); key_valid  = 1'b0; endtask
    task automatic pulse_start(); start      = 1'b1; step(); start      = 1'b0; endtask
    task automatic pulse_stop();  stop_clear = 1'b1; step(); stop_clear = 1'b0; endtask
    task automatic pulse_tick();  tick_1hz   = 1'b1; step(); tick_1hz   = 1'b0; endtask

    task automatic go_cook();
        pulse_key();
        pulse_start();
    endtask

    initial begin
        rst = 1'b1; key_valid = 0; start = 0; stop_clear = 0;
        door_closed = 1; timer_zero = 0; tick_1hz = 0;
        step(); step();
        chk("rst_state", state_o, 0);
        chk("rst_mag", mag_on, 0);
        chk("rst_mux", mux_sel, 0);
        chk("rst_beep", beep, 0);
        chk("rst_pulses", {shift_en, clear_timer}, 0);
        rst = 1'b0;
        step();
        chk("idle_after_rst", state_o, 0);

        // Start with no time entered does nothing.
        pulse_start();
        chk("idle_start_state", state_o, 0);
        chk("idle_start_mag", mag_on, 0);

        // Digit entry with saturation at 4.
        base = shift_cnt;
        pulse_key();
        chk("key1_shift", shift_en, 1);
        chk("key1_state", state_o, 1);
        pulse_key(); pulse_key();
        step();
        chk("three_shifts", shift_cnt - base, 3);
        pulse_key(); pulse_key(); pulse_key();
        step();
        chk("saturated_shifts", shift_cnt - base, 4);
        chk("entry_state", state_o, 1);

        timer_zero = 1;
        pulse_start();
        chk("tz_start_state", state_o, 1);
        chk("tz_start_mag", mag_on, 0);
        timer_zero = 0;
        pulse_start();
        chk("cook_state", state_o, 2);
        chk("cook_mux", mux_sel, 1);
        chk("cook_mag", mag_on, 1);

        // Door interlock.
        door_closed = 0;
        step();
        chk("door_open_state", state_o, 3);
        chk("door_open_mag", mag_on, 0);
        chk("door_open_mux", mux_sel, 0);
        pulse_start();
        chk("open_start_state", state_o, 3);
        door_closed = 1;
        pulse_start();
        chk("resume_state", state_o, 2);
        chk("resume_mag", mag_on, 1);

        // Stop in COOK pauses without clearing; stop in PAUSE clears.
        base = clear_cnt;
        pulse_stop();
        chk("cook_stop_state", state_o, 3);
        pulse_stop();
        chk("pause_stop_state", state_o, 0);
        chk("pause_stop_clear", clear_timer, 1);
        step();
        chk("clear_once", clear_cnt - base, 1);

        // Start and stop together in PAUSE: stop wins.
        go_cook();
        door_closed = 0; step(); door_closed = 1;
        start = 1; stop_clear = 1; step(); start = 0; stop_clear = 0;
        chk("start_stop_state", state_o, 0);
        chk("start_stop_mag", mag_on, 0);

        // Door open outranks timer_zero.
        go_cook();
        door_closed = 0; timer_zero = 1; step(); door_closed = 1; timer_zero = 0;
        chk("door_over_tz", state_o, 3);
        pulse_stop();

        // Completion and beep duration.
        go_cook();
        timer_zero = 1; step(); timer_zero = 0;
        chk("done_state", state_o, 4);
        chk("done_beep", beep, 1);
        chk("done_mag", mag_on, 0);
        pulse_tick();
        chk("tick1_state", state_o, 4);
        step(); step();
        pulse_tick();
        chk("tick2_beep", beep, 1);
        pulse_tick();
        chk("tick3_state", state_o, 0);
        chk("tick3_beep", beep, 0);

        // Stop during DONE exits at once.
        go_cook();
        timer_zero = 1; step(); timer_zero = 0;
        pulse_stop();
        chk("done_stop_state", state_o, 0);
        chk("done_stop_beep", beep, 0);

        // Asynchronous reset mid-cook.
        go_cook();
        chk("pre_rst_mag", mag_on, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", state_o, 0);
        chk("async_rst_mag", mag_on, 0);
        chk("async_rst_mux", mux_sel, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_state", state_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
